fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_queue.sv | 86 ++++++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, default
// parameters and the layout of one instruction queue entry.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam int          DEPTH_DEFAULT    = 4;

  // One queue entry is {pc[15:0], word[31:0]}.
  localparam int ENTRY_W = 48;

  // Assemble a queue entry so that word[7:0] is the byte at the entry pc.
  function automatic logic [ENTRY_W-1:0] make_entry(
    input logic [15:0] pc,
    input logic [7:0]  b0,
    input logic [7:0]  b1,
    input logic [7:0]  b2,
    input logic [7:0]  b3
  );
    return {pc, b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous instruction FIFO with push, pop and flush. The head output
// holds the last presented entry once the queue runs empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [ENTRY_W-1:0]     data_i,
  output logic [ENTRY_W-1:0]     head_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      rd_q, rd_d;
  logic [PW-1:0]      wr_q, wr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [ENTRY_W-1:0] last_q;
  logic               pop_ok;
  logic               push_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != FULL) || pop_ok);

  // Pointer and occupancy update; flush wins over any push or pop.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (pop_ok) begin
        rd_d = rd_q + 1'b1;
      end
      if (push_ok) begin
        wr_d = wr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers, plus a copy of the head so it can be held when empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      if (count_q != '0) begin
        last_q <= mem_q[rd_q];
      end
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_q] : last_q;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches through the shared LSU port,
// captures the registered response one cycle later and queues it for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        lsu_busy,
  output logic [15:0] mem_a,
  output logic        mem_re,
  input  logic [7:0]  mem_q0,
  input  logic [7:0]  mem_q1,
  input  logic [7:0]  mem_q2,
  input  logic [7:0]  mem_q3,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [31:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [1:0]  fetch_state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  fetch_state_e       state_q, state_d;
  logic [15:0]        pc_q, pc_d;
  logic               pend_q, pend_d;
  logic [15:0]        pend_pc_q, pend_pc_d;
  logic               issue;
  logic [CW-1:0]      count;
  logic [CW:0]        occupancy;
  logic [ENTRY_W-1:0] head;
  logic               q_valid;

  // The in-flight response reserves a slot so a push can never overflow.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, pend_q};
  assign issue     = (state_q == RUN) && !lsu_busy && !redirect && (occupancy < DEPTH_L);

  // Next-state logic; dropping fetch_en returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (!fetch_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = lsu_busy ? STALL : RUN;
        STALL:   state_d = lsu_busy ? STALL : RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // PC and pending-response tracking; a redirect discards the pending response.
  always_comb begin
    pc_d      = pc_q;
    pend_d    = issue;
    pend_pc_d = pend_pc_q;
    if (redirect) begin
      pc_d   = redirect_pc;
      pend_d = 1'b0;
    end else if (issue) begin
      pc_d      = pc_q + 16'd4;
      pend_pc_d = pc_q;
    end
  end

  // State, PC and pending-slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (pend_q && !redirect),
    .pop_i   (instr_ready),
    .flush_i (redirect),
    .data_i  (make_entry(pend_pc_q, mem_q0, mem_q1, mem_q2, mem_q3)),
    .head_o  (head),
    .valid_o (q_valid),
    .count_o (count)
  );

  assign mem_a       = pc_q;
  assign mem_re      = issue;
  assign instr       = head[31:0];
  assign instr_pc    = head[47:32];
  assign instr_valid = q_valid;
  assign fetch_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a ROM-backed LSU model, a queue-level
// reference model compared every cycle, and directed scenarios with literal
// expectations.
module tb_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en, lsu_busy, redirect, instr_ready;
  logic [15:0] redirect_pc;
  logic [15:0] mem_a;
  logic        mem_re;
  logic [7:0]  mem_q0 = 8'h00, mem_q1 = 8'h00, mem_q2 = 8'h00, mem_q3 = 8'h00;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic [1:0]  fetch_state;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  fetch_unit #(
    .RESET_PC(RST_PC),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .lsu_busy(lsu_busy),
    .mem_a(mem_a), .mem_re(mem_re),
    .mem_q0(mem_q0), .mem_q1(mem_q1), .mem_q2(mem_q2), .mem_q3(mem_q3),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fetch_state(fetch_state)
  );

  always #5 clk = ~clk;

  // ROM contents: a fixed prologue at 0x0000, a scrambled pattern elsewhere.
  function automatic logic [7:0] romByte(input logic [15:0] a);
    logic [7:0] lo, hi;
    case (a)
      16'h0000: return 8'h11;
      16'h0001: return 8'h22;
      16'h0002: return 8'h33;
      16'h0003: return 8'h44;
      default: begin
        lo = a[7:0];
        hi = a[15:8];
        return (lo * 8'd7) ^ (hi + 8'h5D);
      end
    endcase
  endfunction

  function automatic logic [31:0] romWord(input logic [15:0] a);
    return {romByte(a + 16'd3), romByte(a + 16'd2), romByte(a + 16'd1), romByte(a)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic busy, input logic rdy,
                               input logic rd, input logic [15:0] rdpc);
    @(posedge clk);
    #1;
    fetch_en    = fe;
    lsu_busy    = busy;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rdpc;
  endtask

  // LSU model: latch the request mid-cycle, return the bytes one edge later.
  logic        reqRe = 1'b0;
  logic [15:0] reqA  = 16'h0000;
  logic [15:0] issuedAddr[$];
  logic [15:0] acceptedPcs[$];

  always @(negedge clk) begin
    reqRe = (mem_re === 1'b1) && !rst;
    reqA  = mem_a;
    if (reqRe) issuedAddr.push_back(mem_a);
    if (!rst && !redirect && instr_valid === 1'b1 && instr_ready) acceptedPcs.push_back(instr_pc);
  end

  always @(posedge clk) begin
    if (reqRe) begin
      mem_q0 <= romByte(reqA);
      mem_q1 <= romByte(reqA + 16'd1);
      mem_q2 <= romByte(reqA + 16'd2);
      mem_q3 <= romByte(reqA + 16'd3);
    end
  end

  // Reference model: a queue of {pc, word} entries plus a fetch pointer.
  typedef struct {
    logic [15:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t      mq[$];
  entry_t      mShown;
  logic [15:0] mPc;
  bit          mPend;
  logic [15:0] mPendPc;
  int          mState;
  bit          mIss;

  function automatic bit modelIssue();
    return (mState == 1) && !lsu_busy && !redirect && ((mq.size() + int'(mPend)) < DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mPc     = RST_PC;
      mPend   = 0;
      mPendPc = 16'h0000;
      mState  = 0;
      mShown  = '{16'h0000, 32'h0};
    end else begin
      mIss = modelIssue();
      if (redirect) begin
        mq.delete();
        mPend = 0;
        mPc   = redirect_pc;
      end else begin
        if (instr_ready && mq.size() > 0) void'(mq.pop_front());
        if (mPend) mq.push_back('{mPendPc, romWord(mPendPc)});
        mPend = mIss;
        if (mIss) begin
          mPendPc = mPc;
          mPc     = mPc + 16'd4;
        end
      end
      if (!fetch_en)        mState = 0;
      else if (mState == 0) mState = 1;
      else                  mState = lsu_busy ? 2 : 1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      entry_t e;
      e = (mq.size() > 0) ? mq[0] : mShown;
      checkOutput("m_mem_re", {31'b0, mem_re}, {31'b0, modelIssue()});
      checkOutput("m_mem_a", {16'b0, mem_a}, {16'b0, mPc});
      checkOutput("m_valid", {31'b0, instr_valid}, {31'b0, mq.size() > 0});
      checkOutput("m_state", {30'b0, fetch_state}, 32'(mState));
      checkOutput("m_instr", instr, e.word);
      checkOutput("m_instr_pc", {16'b0, instr_pc}, {16'b0, e.pc});
      if (mq.size() > 0) mShown = mq[0];
    end
  end

  task automatic waitIssueAt(input logic [15:0] addr, input int budget, input string name);
    bit found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_re === 1'b1 && mem_a === addr) begin
        found = 1;
        break;
      end
    end
    checkOutput(name, {31'b0, found}, 32'd1);
  endtask

  initial begin
    int n20;
    int nBefore;
    logic [15:0] prevIssue;
    bit seen;

    rst = 1'b0;
    fetch_en = 0; lsu_busy = 0; redirect = 0; instr_ready = 0; redirect_pc = 16'h0;
    #1 rst = 1'b1;
    checkEn = 1;

    // Reset values
    @(negedge clk);
    checkOutput("reset_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("reset_state", {30'b0, fetch_state}, 32'd0);
    checkOutput("reset_mem_re", {31'b0, mem_re}, 32'd0);
    checkOutput("reset_instr", instr, 32'h0);
    checkOutput("reset_mem_a", {16'b0, mem_a}, 32'h0000);

    // First fetch from 0x0000
    @(posedge clk); #1;
    rst = 1'b0;
    fetch_en = 1;
    repeat (2) @(negedge clk);
    checkOutput("first_mem_re", {31'b0, mem_re}, 32'd1);
    checkOutput("first_mem_a", {16'b0, mem_a}, 32'h0000);
    checkOutput("first_state", {30'b0, fetch_state}, 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("first_instr", instr, 32'h44332211);
    checkOutput("first_instr_pc", {16'b0, instr_pc}, 32'h0000);
    checkOutput("first_valid", {31'b0, instr_valid}, 32'd1);

    // Full queue: four issues then silence; one pop frees exactly one slot
    repeat (6) @(negedge clk);
    checkOutput("full_issue_count", 32'(issuedAddr.size()), 32'd4);
    checkOutput("full_last_addr", {16'b0, issuedAddr[issuedAddr.size()-1]}, 32'h000C);
    checkOutput("full_mem_re", {31'b0, mem_re}, 32'd0);
    applyStimulus(1, 0, 1, 0, 16'h0);
    applyStimulus(1, 0, 0, 0, 16'h0);
    @(negedge clk);
    checkOutput("refill_mem_re", {31'b0, mem_re}, 32'd1);
    checkOutput("refill_mem_a", {16'b0, mem_a}, 32'h0010);
    checkOutput("head_after_pop", {16'b0, instr_pc}, 32'h0004);

    // IDLE keeps the queue and still captures the pending response
    applyStimulus(0, 0, 0, 0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_state", {30'b0, fetch_state}, 32'd0);
    checkOutput("idle_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("idle_head_pc", {16'b0, instr_pc}, 32'h0004);
    checkOutput("idle_issue_count", 32'(issuedAddr.size()), 32'd5);

    // Redirect while 0x0020 is in flight
    applyStimulus(1, 0, 1, 0, 16'h0);
    waitIssueAt(16'h0020, 40, "wait_issue_0020");
    applyStimulus(1, 0, 1, 1, 16'h1235);
    applyStimulus(1, 0, 1, 0, 16'h0);
    @(negedge clk);
    checkOutput("redirect_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("redirect_mem_a", {16'b0, mem_a}, 32'h1235);
    checkOutput("redirect_mem_re", {31'b0, mem_re}, 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("redirect_refill", {31'b0, seen}, 32'd1);
    checkOutput("redirect_head_pc", {16'b0, instr_pc}, 32'h1235);
    n20 = 0;
    foreach (acceptedPcs[i]) if (acceptedPcs[i] == 16'h0020) n20++;
    checkOutput("dropped_0020", 32'(n20), 32'd0);

    // LSU contention for three cycles
    repeat (4) @(posedge clk);
    applyStimulus(1, 1, 1, 0, 16'h0);
    nBefore   = issuedAddr.size();
    prevIssue = issuedAddr[nBefore-1];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("busy_mem_re", {31'b0, mem_re}, 32'd0);
      if (i > 0) checkOutput("busy_state", {30'b0, fetch_state}, 32'd2);
    end
    applyStimulus(1, 0, 1, 0, 16'h0);
    waitIssueAt(prevIssue + 16'd4, 6, "resume_next_pc");
    checkOutput("resume_no_skip", 32'(issuedAddr.size()), 32'(nBefore));

    // PC wrap at the top of the address space
    applyStimulus(1, 0, 1, 1, 16'hFFF8);
    applyStimulus(1, 0, 1, 0, 16'h0);
    waitIssueAt(16'hFFFC, 10, "wait_issue_fffc");
    @(negedge clk);
    checkOutput("wrap_mem_a", {16'b0, mem_a}, 32'h0000);
    checkOutput("wrap_mem_re", {31'b0, mem_re}, 32'd1);

    // Asynchronous reset mid-cycle, then restart from RESET_PC
    repeat (2) @(negedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checkOutput("async_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("async_state", {30'b0, fetch_state}, 32'd0);
    checkOutput("async_mem_re", {31'b0, mem_re}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_idle", {31'b0, mem_re}, 32'd0);
    waitIssueAt(RST_PC, 5, "post_reset_first_issue");
    repeat (6) @(negedge clk);

    checkEn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
